// File: rtl/rom_load_sched.sv
// rom_load_sched
//   Sits between the HPS ROM-download stream and the Green Beret core.
//   Each downloaded byte is decoded into one of four ROM regions and
//   re-issued one cycle later as a region-relative write. The block also
//   owns the core reset: held during download, for a settle window after
//   it, and again after any external game-reset request.
//
// Ports
//   clk48M      in   system clock, all logic on the rising edge
//   reset       in   asynchronous active-high block reset
//   ext_rst     in   synchronous game-reset request (level)
//   dl_active   in   download in progress
//   dl_wr       in   one-cycle byte strobe
//   dl_addr     in   [24:0] byte address
//   dl_data     in   [7:0]  byte
//   wr_cpu      out  CPU ROM write strobe
//   wr_chr      out  character ROM write strobe
//   wr_spr      out  sprite ROM write strobe
//   wr_prom     out  colour/LUT PROM write strobe
//   wr_addr     out  [16:0] region-relative address
//   wr_data     out  [7:0]  registered byte
//   core_reset  out  active-high reset to the game core
//   load_done   out  sticky: last download completed
//   overrun     out  sticky: byte at/above OVR_BASE in current load
//   byte_count  out  [17:0] accepted bytes in current load, saturating
module rom_load_sched #(
    parameter int unsigned  SETTLE_CYCLES = 4096,
    parameter logic [24:0]  OVR_BASE      = 25'h20300
) (
    input  logic        clk48M,
    input  logic        reset,
    input  logic        ext_rst,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        wr_cpu,
    output logic        wr_chr,
    output logic        wr_spr,
    output logic        wr_prom,
    output logic [16:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        core_reset,
    output logic        load_done,
    output logic        overrun,
    output logic [17:0] byte_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN
    } state_t;

    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
    localparam logic [17:0] COUNT_MAX   = 18'h3FFFF;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        core_reset_q, core_reset_d;
    logic        wr_cpu_q, wr_cpu_d;
    logic        wr_chr_q, wr_chr_d;
    logic        wr_spr_q, wr_spr_d;
    logic        wr_prom_q, wr_prom_d;
    logic [16:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        load_done_q, load_done_d;
    logic        overrun_q, overrun_d;
    logic [17:0] byte_count_q, byte_count_d;

    logic accept;
    logic enter_load;

    // Bytes are only taken while already in LOAD; this also covers the
    // LOAD->SETTLE edge, where dl_active has already dropped.
    assign accept = (state_q == ST_LOAD) && dl_wr;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (dl_active) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!dl_active) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                // A new download wins over everything; an external reset
                // keeps restarting the window until it is released.
                if (dl_active)         state_d = ST_LOAD;
                else if (ext_rst)      cnt_d   = SETTLE_LOAD;
                else if (cnt_q == '0)  state_d = ST_RUN;
                else                   cnt_d   = cnt_q - 16'd1;
            end
            ST_RUN: begin
                if (dl_active) begin
                    state_d = ST_LOAD;
                end else if (ext_rst) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Core reset is registered from the next state so it drops exactly on
    // the edge that enters RUN.
    assign core_reset_d = (state_d != ST_RUN);
    assign enter_load   = (state_d == ST_LOAD) && (state_q != ST_LOAD);

    // Region decode and write path.
    always_comb begin
        wr_cpu_d  = 1'b0;
        wr_chr_d  = 1'b0;
        wr_spr_d  = 1'b0;
        wr_prom_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        overrun_d = overrun_q;

        if (enter_load) begin
            overrun_d = 1'b0;
        end else if (accept) begin
            if (dl_addr < 25'h0C000) begin
                wr_cpu_d  = 1'b1;
                wr_addr_d = dl_addr[16:0];
                wr_data_d = dl_data;
            end else if (dl_addr < 25'h10000) begin
                wr_chr_d  = 1'b1;
                wr_addr_d = dl_addr[16:0] - 17'h0C000;
                wr_data_d = dl_data;
            end else if (dl_addr < 25'h20000) begin
                wr_spr_d  = 1'b1;
                wr_addr_d = dl_addr[16:0] - 17'h10000;
                wr_data_d = dl_data;
            end else if (dl_addr < OVR_BASE) begin
                // PROM offset 0x20000 has all-zero low 17 bits.
                wr_prom_d = 1'b1;
                wr_addr_d = dl_addr[16:0];
                wr_data_d = dl_data;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Sticky status and byte counter; entering LOAD clears them.
    always_comb begin
        load_done_d  = load_done_q;
        byte_count_d = byte_count_q;
        if (enter_load) begin
            load_done_d  = 1'b0;
            byte_count_d = '0;
        end else begin
            if (state_q == ST_LOAD && state_d == ST_SETTLE) load_done_d = 1'b1;
            if (accept && byte_count_q != COUNT_MAX)
                byte_count_d = byte_count_q + 18'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers sample the same pre-edge values regardless of order.
    always_ff @(posedge clk48M or posedge reset) begin
        if (reset) begin
            // NOTE: the data/address holding registers are reset too, because
            // their values are visible on the ports and have defined reset
            // values.
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            core_reset_q <= 1'b1;
            wr_cpu_q     <= 1'b0;
            wr_chr_q     <= 1'b0;
            wr_spr_q     <= 1'b0;
            wr_prom_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            load_done_q  <= 1'b0;
            overrun_q    <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_reset_q <= core_reset_d;
            wr_cpu_q     <= wr_cpu_d;
            wr_chr_q     <= wr_chr_d;
            wr_spr_q     <= wr_spr_d;
            wr_prom_q    <= wr_prom_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            load_done_q  <= load_done_d;
            overrun_q    <= overrun_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign wr_cpu     = wr_cpu_q;
    assign wr_chr     = wr_chr_q;
    assign wr_spr     = wr_spr_q;
    assign wr_prom    = wr_prom_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign core_reset = core_reset_q;
    assign load_done  = load_done_q;
    assign overrun    = overrun_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_rom_load_sched.sv
// tb_rom_load_sched
//   Directed bench for rom_load_sched with SETTLE_CYCLES = 16. Inputs change
//   1 ns after a rising edge; outputs are sampled at the same point, so each
//   sample shows the result of the edge just taken.
module tb_rom_load_sched;

    localparam int SETTLE = 16;

    logic        clk48M = 1'b0;
    logic        reset;
    logic        ext_rst;
    logic        dl_active;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        wr_cpu, wr_chr, wr_spr, wr_prom;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        core_reset, load_done, overrun;
    logic [17:0] byte_count;

    int n_checks = 0;
    int n_errors = 0;

    rom_load_sched #(
        .SETTLE_CYCLES(SETTLE),
        .OVR_BASE     (25'h20300)
    ) dut (
        .clk48M    (clk48M),
        .reset     (reset),
        .ext_rst   (ext_rst),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .wr_cpu    (wr_cpu),
        .wr_chr    (wr_chr),
        .wr_spr    (wr_spr),
        .wr_prom   (wr_prom),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .core_reset(core_reset),
        .load_done (load_done),
        .overrun   (overrun),
        .byte_count(byte_count)
    );

    always #10 clk48M = ~clk48M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk48M);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [3:0] strobes();
        return {wr_cpu, wr_chr, wr_spr, wr_prom};
    endfunction

    // One byte at 2-cycle spacing: strobe/addr/data after the accepting
    // edge, then strobe low with addr/data held after the following edge.
    task automatic send(input string tag, input logic [24:0] a, input logic [7:0] d,
                        input logic [3:0] exp_strb, input logic [16:0] exp_addr,
                        input logic [7:0] exp_data);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        tick();
        dl_wr = 1'b0;
        check({tag, " strobe"}, 32'(strobes()), 32'(exp_strb));
        check({tag, " addr"},   32'(wr_addr),   32'(exp_addr));
        check({tag, " data"},   32'(wr_data),   32'(exp_data));
        tick();
        check({tag, " strobe off"}, 32'(strobes()), 32'd0);
        check({tag, " addr hold"},  32'(wr_addr),   32'(exp_addr));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        ext_rst   = 1'b0;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        dl_data   = '0;
        ticks(2);

        // Reset state
        check("rst core_reset", 32'(core_reset), 32'd1);
        check("rst strobes",    32'(strobes()),  32'd0);
        check("rst load_done",  32'(load_done),  32'd0);
        check("rst overrun",    32'(overrun),    32'd0);
        check("rst byte_count", 32'(byte_count), 32'd0);
        check("rst wr_addr",    32'(wr_addr),    32'd0);
        check("rst wr_data",    32'(wr_data),    32'd0);
        reset = 1'b0;
        tick();
        check("idle core_reset", 32'(core_reset), 32'd1);

        // First download: one byte per region plus region boundaries
        dl_active = 1'b1;
        tick();
        check("load core_reset", 32'(core_reset), 32'd1);
        send("cpu0",   25'h00000, 8'hAA, 4'b1000, 17'h00000, 8'hAA);
        send("chr1",   25'h0C001, 8'h55, 4'b0100, 17'h00001, 8'h55);
        send("spr2",   25'h10002, 8'h11, 4'b0010, 17'h00002, 8'h11);
        send("prom1f", 25'h2001F, 8'h22, 4'b0001, 17'h0001F, 8'h22);
        check("bc4", 32'(byte_count), 32'd4);
        send("cpu top",  25'h0BFFF, 8'h01, 4'b1000, 17'h0BFFF, 8'h01);
        send("chr base", 25'h0C000, 8'h02, 4'b0100, 17'h00000, 8'h02);
        send("spr top",  25'h1FFFF, 8'h03, 4'b0010, 17'h0FFFF, 8'h03);
        send("prom top", 25'h202FF, 8'h04, 4'b0001, 17'h002FF, 8'h04);
        check("bc8", 32'(byte_count), 32'd8);
        check("no overrun yet", 32'(overrun), 32'd0);

        // End of download: settle window of 16 cycles
        dl_active = 1'b0;
        tick();
        check("load_done set",     32'(load_done),  32'd1);
        check("settle core_reset", 32'(core_reset), 32'd1);
        ticks(SETTLE - 1);
        check("settle last cycle", 32'(core_reset), 32'd1);
        tick();
        check("run core_reset",    32'(core_reset), 32'd0);
        ticks(3);
        check("run stays",         32'(core_reset), 32'd0);
        check("load_done sticky",  32'(load_done),  32'd1);

        // External reset in RUN for 3 cycles
        ext_rst = 1'b1;
        tick();
        check("ext_rst rise", 32'(core_reset), 32'd1);
        ticks(2);
        ext_rst = 1'b0;
        ticks(SETTLE - 1);
        check("ext_rst hold", 32'(core_reset), 32'd1);
        tick();
        check("ext_rst fall", 32'(core_reset), 32'd0);

        // New download from RUN clears sticky state; overrun byte
        dl_active = 1'b1;
        tick();
        check("reload core_reset", 32'(core_reset), 32'd1);
        check("reload load_done",  32'(load_done),  32'd0);
        check("reload bc",         32'(byte_count), 32'd0);
        send("ovr", 25'h20300, 8'h99, 4'b0000, 17'h002FF, 8'h04);
        check("ovr flag", 32'(overrun),    32'd1);
        check("ovr bc",   32'(byte_count), 32'd1);

        // Byte in the same cycle dl_active falls is still accepted
        dl_active = 1'b0;
        dl_wr     = 1'b1;
        dl_addr   = 25'h00010;
        dl_data   = 8'h5A;
        tick();
        dl_wr = 1'b0;
        check("fall byte strobe", 32'(strobes()),  32'b1000);
        check("fall byte addr",   32'(wr_addr),    32'h10);
        check("fall byte data",   32'(wr_data),    32'h5A);
        check("fall bc",          32'(byte_count), 32'd2);
        check("fall load_done",   32'(load_done),  32'd1);
        check("fall overrun",     32'(overrun),    32'd1);

        // dl_active returns during SETTLE with counter = 3; a dl_wr on the
        // same edge must be ignored
        ticks(SETTLE - 4);
        dl_active = 1'b1;
        dl_wr     = 1'b1;
        dl_addr   = 25'h00020;
        dl_data   = 8'hEE;
        tick();
        dl_wr = 1'b0;
        check("resettle core_reset", 32'(core_reset), 32'd1);
        check("resettle load_done",  32'(load_done),  32'd0);
        check("resettle overrun",    32'(overrun),    32'd0);
        check("resettle bc",         32'(byte_count), 32'd0);
        check("resettle no strobe",  32'(strobes()),  32'd0);
        ticks(SETTLE + 2);
        check("load holds reset", 32'(core_reset), 32'd1);

        // 100 back-to-back bytes, then asynchronous reset mid-load
        for (int i = 0; i < 100; i++) begin
            dl_wr   = 1'b1;
            dl_addr = 25'(i);
            dl_data = 8'(i);
            tick();
        end
        check("b2b bc",     32'(byte_count), 32'd100);
        check("b2b strobe", 32'(strobes()),  32'b1000);
        check("b2b addr",   32'(wr_addr),    32'd99);
        reset = 1'b1;
        #2;
        check("async bc",         32'(byte_count), 32'd0);
        check("async strobes",    32'(strobes()),  32'd0);
        check("async core_reset", 32'(core_reset), 32'd1);
        check("async wr_addr",    32'(wr_addr),    32'd0);
        dl_wr = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("relaunch core_reset", 32'(core_reset), 32'd1);
        send("relaunch chr", 25'h0C005, 8'h77, 4'b0100, 17'h00005, 8'h77);
        check("relaunch bc", 32'(byte_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rom_load_sched.md
# rom_load_sched

Sequencer between the HPS ROM-download stream and the Green Beret game core. It decodes each downloaded byte into one of four on-chip ROM regions and emits a registered write strobe for that region. It also owns the core's reset: the core is held in reset during download and for a settle window afterwards, and again after any external reset request. It sits in the top level between `hps_io` and `FPGA_GreenBeret`, replacing the raw `ioctl_wr` / `iRST` wiring.

## Interface
Parameters:
- `SETTLE_CYCLES`, 4096: clk48M cycles the core stays in reset after download end or external reset; legal range 1..65535.
- `OVR_BASE`, 25'h20300: first address outside the region map.

Ports:
- `clk48M`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high block reset.
- `ext_rst`  in  1  synchronous game-reset request (status/OSD/button), level.
- `dl_active`  in  1  download in progress (ioctl_download).
- `dl_wr`  in  1  one-cycle byte strobe.
- `dl_addr`  in  25  byte address.
- `dl_data`  in  8  byte.
- `wr_cpu`  out  1  CPU ROM write strobe.
- `wr_chr`  out  1  character ROM write strobe.
- `wr_spr`  out  1  sprite ROM write strobe.
- `wr_prom`  out  1  colour/LUT PROM write strobe.
- `wr_addr`  out  17  region-relative address.
- `wr_data`  out  8  registered byte.
- `core_reset`  out  1  reset to game core, active-high.
- `load_done`  out  1  sticky: last download completed.
- `overrun`  out  1  sticky: byte at or above `OVR_BASE` seen in current load.
- `byte_count`  out  18  accepted bytes in current load, saturating at 18'h3FFFF.

## Operation
- Region map, applied to `dl_addr`:
  - CPU: 0x00000–0x0BFFF, offset 0.
  - CHR: 0x0C000–0x0FFFF, offset 0x0C000.
  - SPR: 0x10000–0x1FFFF, offset 0x10000.
  - PROM: 0x20000–(`OVR_BASE`-1), offset 0x20000.
  - At or above `OVR_BASE`: no strobe; sets `overrun`.
- `wr_addr` = `dl_addr` minus region offset, truncated to 17 bits.
- States: IDLE, LOAD, SETTLE, RUN.
- IDLE: entered on `reset`. `core_reset`=1. `dl_active`=1 → LOAD.
- LOAD: `core_reset`=1.
  - Each `dl_wr` decodes a region and increments `byte_count` (saturating). The overrun case also counts.
  - `dl_active`=0 → SETTLE. On that transition, set `load_done` and load the settle counter with `SETTLE_CYCLES`-1.
- SETTLE: `core_reset`=1; counter decrements each cycle.
  - Counter 0 → RUN.
  - `dl_active`=1 → LOAD (priority over counter expiry).
  - `ext_rst`=1 → counter reloads; state stays SETTLE.
- RUN: `core_reset`=0.
  - `dl_active`=1 → LOAD.
  - Else `ext_rst`=1 → SETTLE with counter reload.
- Entering LOAD from any state clears `load_done`, `overrun` and `byte_count` in the same edge.
- `dl_wr` is ignored outside LOAD, including the IDLE/SETTLE/RUN→LOAD transition cycle if `dl_active` and `dl_wr` rise together. Source guarantees ≥1 cycle gap.
- A `dl_wr` in the cycle `dl_active` falls (LOAD→SETTLE edge) is still accepted and strobed.
- `ext_rst` in IDLE or LOAD has no effect.

## Timing
- Reset values:
  - state IDLE, `core_reset`=1.
  - All `wr_*` strobes, `load_done`, `overrun` = 0.
  - `byte_count`=0, `wr_addr`=0, `wr_data`=0.
- Write path latency 1 cycle: `dl_wr` at edge N → exactly one `wr_*` high for edge N+1 only, with matching `wr_addr`/`wr_data`. At most one strobe high in any cycle.
- `wr_addr`/`wr_data` hold their last value when no strobe is active.
- `core_reset` is registered:
  - Rises 1 cycle after `dl_active` rises in RUN/SETTLE.
  - Falls exactly `SETTLE_CYCLES` cycles after the SETTLE entry edge.
  - After `ext_rst` deasserts in SETTLE, falls `SETTLE_CYCLES` cycles after the last `ext_rst` cycle.
- `load_done` rises the cycle after `dl_active` falls; `overrun` the cycle after the offending `dl_wr`.
- Asynchronous `reset` mid-load: immediate IDLE. Strobes drop, counters clear, `core_reset`=1.

## Test plan
- Reset, download bytes 0x00000 (0xAA), 0x0C001 (0x55), 0x10002 (0x11), 0x2001F (0x22) at 2-cycle spacing.
  - Expect `wr_cpu`/addr 0/0xAA, `wr_chr`/1/0x55, `wr_spr`/2/0x11, `wr_prom`/0x1F/0x22, each one cycle after its `dl_wr`.
  - Expect `byte_count`=4.
- `dl_active` falls at edge N with `SETTLE_CYCLES`=16.
  - `load_done`=1 at N+1; `core_reset` falls at N+16; RUN reached.
- In RUN, pulse `ext_rst` for 3 cycles.
  - `core_reset`=1 next cycle; falls 16 cycles after the last `ext_rst` cycle.
- Write to 0x20300 during load.
  - No strobe; `overrun`=1 next cycle; `byte_count` incremented.
  - A new download clears `overrun`, `load_done` and `byte_count`.
- Assert `reset` mid-load after 100 bytes.
  - `byte_count`=0, no strobes, `core_reset`=1, state IDLE.
  - Next `dl_active` re-enters LOAD.
- `dl_active` rises during SETTLE with counter=3.
  - State LOAD; `core_reset` stays 1; `load_done` cleared.
